// File: rtl/itype_pkg.sv
// itype_pkg: shared constants and state encoding for the I-type program loader.
`timescale 1ns/1ps
`default_nettype none

package itype_pkg;

  localparam int OPCODE_W = 7;
  localparam int REG_W    = 5;
  localparam int FUNCT3_W = 3;
  localparam int IMM_W    = 12;
  localparam int WORD_W   = 32;

  localparam logic [OPCODE_W-1:0] OP_IMM  = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LOAD = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_JALR = 7'b1100111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/itype_encoder.sv
// itype_encoder: packs I-type fields into a 32-bit word and flags illegal bundles.
// Legality checking is compiled in only when ITYPE_CHECK_EN is defined.
`timescale 1ns/1ps
`default_nettype none

module itype_encoder
  import itype_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [REG_W-1:0]    rd,
  input  logic [FUNCT3_W-1:0] funct3,
  input  logic [REG_W-1:0]    rs1,
  input  logic [IMM_W-1:0]    imm,
  output logic [WORD_W-1:0]   word,
  output logic                legal
);

  assign word = {imm, rs1, funct3, rd, opcode};

`ifdef ITYPE_CHECK_EN
  // Shift-immediate forms carry funct7 in imm[11:5]; only SRAI may use 0100000.
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_IMM: begin
        legal = 1'b1;
        if ((funct3 == 3'b001) && (imm[11:5] != 7'd0))
          legal = 1'b0;
        if ((funct3 == 3'b101) && (imm[11:5] != 7'd0) && (imm[11:5] != 7'b0100000))
          legal = 1'b0;
      end
      OP_LOAD: legal = 1'b1;
      OP_JALR: legal = (funct3 == 3'b000);
      default: legal = 1'b0;
    endcase
  end
`else
  assign legal = 1'b1;
`endif

endmodule

`default_nettype wire

// File: rtl/itype_prog_loader.sv
// itype_prog_loader: streams I-type bundles into sequential instruction-memory words,
// then raises core_run. Optional legality check via ITYPE_CHECK_EN (adds err_illegal).
`timescale 1ns/1ps
`default_nettype none

module itype_prog_loader
  import itype_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_last,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [REG_W-1:0]    rd,
  input  logic [FUNCT3_W-1:0] funct3,
  input  logic [REG_W-1:0]    rs1,
  input  logic [IMM_W-1:0]    imm,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  output logic [ADDR_W:0]     count,
  output logic                core_run,
  output logic                err_full
`ifdef ITYPE_CHECK_EN
  ,
  output logic                err_illegal
`endif
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  state_t              state;
  state_t              state_next;
  logic [WORD_W-1:0]   word;
  logic                legal;
  logic                accept;
  logic                write;
  logic                fills;
  logic                clear_session;
  logic [ADDR_W:0]     count_inc;

  itype_encoder u_encoder (
    .opcode (opcode),
    .rd     (rd),
    .funct3 (funct3),
    .rs1    (rs1),
    .imm    (imm),
    .word   (word),
    .legal  (legal)
  );

  assign accept        = in_valid && (state == LOAD);
  assign write         = accept && legal;
  assign count_inc     = count + 1'b1;
  assign fills         = write && (count_inc == DEPTH_CNT);
  assign clear_session = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = LOAD;
      LOAD:  if (accept && (in_last || fills)) state_next = DRAIN;
      DRAIN: state_next = DONE;
      DONE:  if (start) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      core_run  <= 1'b0;
      err_full  <= 1'b0;
    end else begin
      mem_we   <= write;
      core_run <= (state_next == DONE);
      if (write) begin
        mem_addr  <= count[ADDR_W-1:0];
        mem_wdata <= word;
      end
      if (clear_session)  count <= '0;
      else if (write)     count <= count_inc;
      // A bundle that both fills memory and ends the program is a clean finish.
      if (clear_session)          err_full <= 1'b0;
      else if (fills && !in_last) err_full <= 1'b1;
    end
  end

`ifdef ITYPE_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  err_illegal <= 1'b0;
    else if (clear_session)      err_illegal <= 1'b0;
    else if (accept && !legal)   err_illegal <= 1'b1;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_itype_prog_loader.sv
// tb_itype_prog_loader: directed self-checking bench for itype_prog_loader.
`timescale 1ns/1ps
`default_nettype none

module tb_itype_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [11:0] imm;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [5:0]  count;
  logic        core_run;
  logic        err_full;
`ifdef ITYPE_CHECK_EN
  logic        err_illegal;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  itype_prog_loader #(.ADDR_W(5), .DEPTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .opcode    (opcode),
    .rd        (rd),
    .funct3    (funct3),
    .rs1       (rs1),
    .imm       (imm),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .count     (count),
    .core_run  (core_run),
    .err_full  (err_full)
`ifdef ITYPE_CHECK_EN
    ,
    .err_illegal (err_illegal)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bundle(input logic [6:0] op, input logic [4:0] d, input logic [2:0] f3,
                            input logic [4:0] s1, input logic [11:0] im, input logic last);
    opcode = op; rd = d; funct3 = f3; rs1 = s1; imm = im; in_last = last; in_valid = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    opcode = '0; rd = '0; funct3 = '0; rs1 = '0; imm = '0;
    step(); step();
    checks++;
    if ({mem_we, mem_addr, mem_wdata, count, core_run, err_full, in_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b addr=%h data=%h cnt=%0d run=%b full=%b rdy=%b, expected all 0",
               mem_we, mem_addr, mem_wdata, count, core_run, err_full, in_ready);
    end
    rst_n = 1'b1;
    // Bundles offered in IDLE must be ignored.
    set_bundle(7'h13, 5'd3, 3'd0, 5'd0, 12'd7, 1'b0);
    step(); step();
    checks++;
    if (in_ready !== 1'b0 || mem_we !== 1'b0 || count !== 6'd0) begin
      errors++;
      $display("FAIL idle_backpressure: got rdy=%b we=%b cnt=%0d, expected 0 0 0", in_ready, mem_we, count);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_basic_load();
    pulse_start();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL load_ready: got %b expected 1", in_ready);
    end
    set_bundle(7'h13, 5'd1, 3'd0, 5'd0, 12'h005, 1'b0);
    step();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 5'd0 || mem_wdata !== 32'h00500093 || count !== 6'd1) begin
      errors++;
      $display("FAIL basic_word0: got we=%b addr=%0d data=%h cnt=%0d, expected 1 0 00500093 1",
               mem_we, mem_addr, mem_wdata, count);
    end
    set_bundle(7'h13, 5'd2, 3'd0, 5'd1, 12'hFFF, 1'b1);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 5'd1 || mem_wdata !== 32'hFFF08113 || count !== 6'd2 ||
        in_ready !== 1'b0 || core_run !== 1'b0) begin
      errors++;
      $display("FAIL basic_word1: got we=%b addr=%0d data=%h cnt=%0d rdy=%b run=%b, expected 1 1 fff08113 2 0 0",
               mem_we, mem_addr, mem_wdata, count, in_ready, core_run);
    end
    step();
    checks++;
    if (core_run !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 5'd1 || mem_wdata !== 32'hFFF08113) begin
      errors++;
      $display("FAIL basic_run: got run=%b we=%b addr=%0d data=%h, expected 1 0 1 fff08113",
               core_run, mem_we, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_done_backpressure();
    set_bundle(7'h13, 5'd9, 3'd0, 5'd9, 12'h111, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (in_ready !== 1'b0 || mem_we !== 1'b0 || count !== 6'd2 || core_run !== 1'b1) begin
        errors++;
        $display("FAIL done_backpressure[%0d]: got rdy=%b we=%b cnt=%0d run=%b, expected 0 0 2 1",
                 i, in_ready, mem_we, count, core_run);
      end
    end
    in_valid = 1'b0;
    pulse_start();
    checks++;
    if (core_run !== 1'b0 || count !== 6'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart: got run=%b cnt=%0d rdy=%b, expected 0 0 1", core_run, count, in_ready);
    end
    set_bundle(7'h03, 5'd4, 3'd2, 5'd5, 12'h010, 1'b1);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 5'd0 || mem_wdata !== 32'h0102A203) begin
      errors++;
      $display("FAIL restart_addr0: got we=%b addr=%0d data=%h, expected 1 0 0102a203", mem_we, mem_addr, mem_wdata);
    end
    step();
  endtask

  task automatic test_full(input logic last_at_end);
    logic [31:0] exp_word;
    logic [11:0] im;
    logic [4:0]  d;
    logic [4:0]  s1;
    pulse_start();
    for (int i = 0; i < 32; i++) begin
      im = 12'(i * 100);
      d  = 5'(i);
      s1 = 5'(31 - i);
      exp_word = {im, s1, 3'd2, d, 7'h03};
      set_bundle(7'h03, d, 3'd2, s1, im, (i == 31) ? last_at_end : 1'b0);
      step();
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 5'(i) || mem_wdata !== exp_word || count !== 6'(i + 1)) begin
        errors++;
        $display("FAIL full_write[%0d]: got we=%b addr=%0d data=%h cnt=%0d, expected 1 %0d %h %0d",
                 i, mem_we, mem_addr, mem_wdata, count, i, exp_word, i + 1);
      end
    end
    checks++;
    if (err_full !== !last_at_end || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_flag(last=%b): got err_full=%b rdy=%b, expected %b 0",
               last_at_end, err_full, in_ready, !last_at_end);
    end
    step();
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (core_run !== 1'b1 || mem_we !== 1'b0 || in_ready !== 1'b0 || count !== 6'd32) begin
      errors++;
      $display("FAIL full_done: got run=%b we=%b rdy=%b cnt=%0d, expected 1 0 0 32", core_run, mem_we, in_ready, count);
    end
  endtask

`ifdef ITYPE_CHECK_EN
  task automatic test_illegal();
    pulse_start();
    set_bundle(7'h13, 5'd1, 3'd0, 5'd0, 12'h005, 1'b0);
    step();
    set_bundle(7'h13, 5'd2, 3'b001, 5'd1, 12'h020, 1'b0);
    step();
    checks++;
    if (mem_we !== 1'b0 || err_illegal !== 1'b1 || count !== 6'd1) begin
      errors++;
      $display("FAIL illegal_drop: got we=%b err_illegal=%b cnt=%0d, expected 0 1 1", mem_we, err_illegal, count);
    end
    set_bundle(7'h13, 5'd2, 3'd0, 5'd1, 12'hFFF, 1'b1);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 5'd1 || mem_wdata !== 32'hFFF08113 || count !== 6'd2) begin
      errors++;
      $display("FAIL illegal_next: got we=%b addr=%0d data=%h cnt=%0d, expected 1 1 fff08113 2",
               mem_we, mem_addr, mem_wdata, count);
    end
    step();
    checks++;
    if (core_run !== 1'b1 || err_illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_done: got run=%b err_illegal=%b, expected 1 1", core_run, err_illegal);
    end
  endtask
`endif

  task automatic test_reset_mid_load();
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      set_bundle(7'h13, 5'(i + 1), 3'd0, 5'd0, 12'(i + 1), 1'b0);
      step();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_we, mem_addr, mem_wdata, count, core_run, err_full, in_ready} !== '0) begin
      errors++;
      $display("FAIL reset_mid_load: got we=%b addr=%h data=%h cnt=%0d run=%b full=%b rdy=%b, expected all 0",
               mem_we, mem_addr, mem_wdata, count, core_run, err_full, in_ready);
    end
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    pulse_start();
    set_bundle(7'h67, 5'd1, 3'd0, 5'd2, 12'h004, 1'b1);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 5'd0 || mem_wdata !== 32'h004100E7 || count !== 6'd1) begin
      errors++;
      $display("FAIL reload_after_reset: got we=%b addr=%0d data=%h cnt=%0d, expected 1 0 004100e7 1",
               mem_we, mem_addr, mem_wdata, count);
    end
    step();
    checks++;
    if (core_run !== 1'b1) begin
      errors++; $display("FAIL reload_run: got %b expected 1", core_run);
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_done_backpressure();
    test_full(1'b0);
    test_full(1'b1);
`ifdef ITYPE_CHECK_EN
    test_illegal();
`endif
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
